// File: rtl/pmux_csr_sequencer.sv
// pmux_csr_sequencer: walks a pin range programming one PMUX port over the CSR bus, then reads back STS and IN
module pmux_csr_sequencer #(
  parameter logic [11:0] BASE_ADDR = 12'h910,
  parameter int NUM_PINS = 32,
  parameter int PIN_W = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PIN_W-1:0]    first_pin,
  input  logic [PIN_W-1:0]    last_pin,
  input  logic [NUM_PINS-1:0] cfg_dir,
  input  logic [NUM_PINS-1:0] cfg_out,
  input  logic [NUM_PINS-1:0] cfg_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         sts_q,
  output logic [31:0]         in_q,
  output logic                csr_req,
  output logic                csr_we,
  output logic [11:0]         csr_addr,
  output logic [31:0]         csr_wdata,
  input  logic                csr_ack,
  input  logic [31:0]         csr_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, W_ADR, W_DIR, W_OUT, W_EN, R_STS, R_IN, GAP, FIN} state_t;
  state_t state_q, state_d, ret_q, ret_d, tgt;
  logic enter;
  logic [PIN_W-1:0] pin_q, pin_d, last_q, last_d;
  logic [NUM_PINS-1:0] dir_q, dir_d, out_q, out_d, en_q, en_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d, we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, sts_d, in_d;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign csr_req = req_q;
  assign csr_we = we_q;
  assign csr_addr = addr_q;
  assign csr_wdata = wdata_q;
  // next-state: every bus transaction is followed by GAP, which then launches the stored successor
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    pin_d = pin_q;
    last_d = last_q;
    dir_d = dir_q;
    out_d = out_q;
    en_d = en_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    sts_d = sts_q;
    in_d = in_q;
    enter = 1'b0;
    tgt = W_ADR;
    unique case (state_q)
      IDLE: begin
        if (start && first_pin <= last_pin) begin
          pin_d = first_pin;
          last_d = last_pin;
          dir_d = cfg_dir;
          out_d = cfg_out;
          en_d = cfg_en;
          err_d = 1'b0;
          busy_d = 1'b1;
          enter = 1'b1;
        end else if (start) begin
          err_d = 1'b1;
          state_d = GAP;
          ret_d = FIN;
        end
      end
      GAP: begin
        if (ret_q == FIN) begin
          state_d = FIN;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          enter = 1'b1;
          tgt = ret_q;
        end
      end
      FIN: state_d = IDLE;
      default: begin
        if (req_q && csr_ack) begin
          req_d = 1'b0;
          state_d = GAP;
          ret_d = state_q == W_ADR ? W_DIR :
                  state_q == W_DIR ? W_OUT :
                  state_q == W_OUT ? W_EN :
                  state_q == W_EN ? (pin_q == last_q ? R_STS : W_ADR) :
                  state_q == R_STS ? R_IN : FIN;
          pin_d = (state_q == W_EN && pin_q != last_q) ? pin_q + 1'b1 : pin_q;
          sts_d = state_q == R_STS ? csr_rdata : sts_q;
          in_d = state_q == R_IN ? csr_rdata : in_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d = 1'b0;
          err_d = 1'b1;
          state_d = GAP;
          ret_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (enter) begin
      state_d = tgt;
      req_d = 1'b1;
      cnt_d = '0;
      we_d = tgt != R_STS && tgt != R_IN;
      addr_d = BASE_ADDR + (tgt == W_ADR ? 12'd3 : tgt == W_DIR ? 12'd4 : tgt == W_OUT ? 12'd5 :
                            tgt == W_EN ? 12'd6 : tgt == R_STS ? 12'd2 : 12'd7);
      wdata_d = tgt == W_ADR ? 32'(pin_d) : tgt == W_DIR ? 32'(dir_q[pin_d]) :
                tgt == W_OUT ? 32'(out_q[pin_d]) : tgt == W_EN ? 32'(en_q[pin_d]) : 32'd0;
    end
  end
  // state and registered outputs; reset abandons any bus transaction immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      pin_q <= '0;
      last_q <= '0;
      dir_q <= '0;
      out_q <= '0;
      en_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      sts_q <= '0;
      in_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      pin_q <= pin_d;
      last_q <= last_d;
      dir_q <= dir_d;
      out_q <= out_d;
      en_q <= en_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      sts_q <= sts_d;
      in_q <= in_d;
    end
  end
endmodule

// File: tb/tb_pmux_csr_sequencer.sv
// tb_pmux_csr_sequencer: scoreboard bench with a randomized CSR responder and a transaction-level model
module tb_pmux_csr_sequencer;
  localparam logic [11:0] BASE = 12'h910;
  localparam int TO = 255;
  typedef struct {bit we; logic [11:0] addr; logic [31:0] data;} txn_t;
  typedef struct {bit err; logic [31:0] sts; logic [31:0] inn; int lat;} res_t;
  logic clk = 0, reset = 1, start = 0;
  logic [4:0] first_pin = 0, last_pin = 0;
  logic [31:0] cfg_dir = 0, cfg_out = 0, cfg_en = 0;
  logic busy, done, err, csr_req, csr_we, csr_ack = 0;
  logic [31:0] sts_q, in_q, csr_wdata, csr_rdata = 0;
  logic [11:0] csr_addr;
  txn_t exp_q[$];
  res_t res_q[$];
  int checks = 0, failures = 0, cyc = 0, start_cyc = 0, lat_acc = 0, n_done = 0, mind = 0, maxd = 0;
  logic [11:0] hang_addr = 0;
  logic [31:0] sts_val = 0, in_val = 0, m_sts = 0, m_in = 0;

  pmux_csr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .first_pin(first_pin), .last_pin(last_pin),
    .cfg_dir(cfg_dir), .cfg_out(cfg_out), .cfg_en(cfg_en), .busy(busy), .done(done), .err(err),
    .sts_q(sts_q), .in_q(in_q), .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_ack(csr_ack), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // responder: random per-transaction wait, never acks hang_addr, tracks expected bus cycles
  initial begin
    int w, d;
    bit acked, bad;
    logic [44:0] sig;
    w = 0; d = 0; acked = 0; bad = 0; sig = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        w = 0; acked = 0; csr_ack = 0;
      end else if (csr_req && !acked) begin
        if (w == 0) begin sig = {csr_we, csr_addr, csr_wdata}; bad = 0; end
        else if (sig != {csr_we, csr_addr, csr_wdata}) bad = 1;
        if (csr_addr != hang_addr && w >= d) begin
          csr_ack = 1; acked = 1;
          csr_rdata = csr_addr == BASE + 12'd2 ? sts_val : csr_addr == BASE + 12'd7 ? in_val : $urandom;
          lat_acc += w + 2;
          if (w > 0) chk("req_stable", bad, 0);
        end else w++;
      end else if (!csr_req) begin
        if (!acked && w > 0) begin
          chk("timeout_req_cycles", w, TO);
          lat_acc += TO + 1;
        end
        csr_ack = 0; acked = 0; w = 0; d = $urandom_range(maxd, mind);
      end
    end
  end

  // monitor: pops expected bus transactions on handshakes and expected results on done
  initial begin
    txn_t t;
    res_t r;
    forever begin
      @(negedge clk);
      #1;
      if (csr_req && csr_ack) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_txn: got addr %h we %0d, required none", csr_addr, csr_we);
        end else begin
          t = exp_q.pop_front();
          chk("txn_we", csr_we, t.we);
          chk("txn_addr", csr_addr, t.addr);
          if (t.we) chk("txn_wdata", csr_wdata, t.data);
        end
      end
      if (done) begin
        n_done++;
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          r = res_q.pop_front();
          chk("err", err, r.err);
          chk("sts_q", sts_q, r.sts);
          chk("in_q", in_q, r.inn);
          chk("busy_at_done", busy, 0);
          chk("latency", cyc - start_cyc, r.lat != 0 ? r.lat : lat_acc + 1);
        end
      end
    end
  end

  task automatic run(input logic [4:0] f, input logic [4:0] l, input bit hang, input int lo, input int hi,
                     input logic [31:0] sv, input logic [31:0] iv);
    int k, n;
    mind = lo; maxd = hi;
    hang_addr = hang ? BASE + 12'd4 : 12'h0;
    sts_val = sv; in_val = iv;
    if (f > l) res_q.push_back('{1, m_sts, m_in, 2});
    else if (hang) begin
      exp_q.push_back('{1, BASE + 12'd3, 32'(f)});
      res_q.push_back('{1, m_sts, m_in, 2 + TO + 1 + 1});
    end else begin
      for (int p = int'(f); p <= int'(l); p++) begin
        exp_q.push_back('{1, BASE + 12'd3, 32'(p)});
        exp_q.push_back('{1, BASE + 12'd4, 32'(cfg_dir[p])});
        exp_q.push_back('{1, BASE + 12'd5, 32'(cfg_out[p])});
        exp_q.push_back('{1, BASE + 12'd6, 32'(cfg_en[p])});
      end
      exp_q.push_back('{0, BASE + 12'd2, 32'd0});
      exp_q.push_back('{0, BASE + 12'd7, 32'd0});
      m_sts = sv; m_in = iv;
      n = int'(l) - int'(f) + 1;
      res_q.push_back('{0, sv, iv, lo == hi ? (4 * n + 2) * (lo + 2) + 1 : 0});
    end
    @(posedge clk);
    #1;
    lat_acc = 0; first_pin = f; last_pin = l; start = 1; start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 0;
    k = n_done;
    for (int i = 0; i < 4000 && n_done == k; i++) @(posedge clk);
    if (n_done == k) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done, required done");
      exp_q.delete(); res_q.delete();
    end
    chk("txn_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [4:0] f, l;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {busy, done, err, csr_req, csr_we}, 0);
    chk("rst_sts_in", {sts_q, in_q}, 0);
    chk("rst_addr_wdata", {csr_addr, csr_wdata}, 0);
    reset = 0;
    cfg_dir = 32'h8; cfg_out = 32'h0; cfg_en = 32'h8;
    run(3, 3, 0, 0, 0, 32'h1, 32'hA5);
    cfg_dir = 32'hFFFF0000; cfg_out = $urandom; cfg_en = $urandom;
    run(0, 31, 0, 0, 0, $urandom, $urandom);
    cfg_dir = $urandom; cfg_out = $urandom; cfg_en = $urandom;
    run(0, 0, 0, 3, 3, $urandom, $urandom);
    run(2, 4, 1, 0, 0, $urandom, $urandom);
    run(2, 2, 0, 0, 0, $urandom, $urandom);
    run(5, 2, 0, 0, 0, $urandom, $urandom);
    cfg_dir = $urandom; cfg_out = $urandom; cfg_en = $urandom;
    fork
      run(0, 3, 0, 0, 1, $urandom, $urandom);
      begin
        repeat (10) @(posedge clk);
        #1;
        start = 1; first_pin = 7; last_pin = 9;
        cfg_dir = ~cfg_dir; cfg_out = ~cfg_out; cfg_en = ~cfg_en;
        @(posedge clk);
        #1;
        start = 0;
      end
    join
    for (int it = 0; it < 8; it++) begin
      cfg_dir = $urandom; cfg_out = $urandom; cfg_en = $urandom;
      f = 5'($urandom_range(0, 31)); l = 5'($urandom_range(0, 31));
      run(f, l, 0, 0, $urandom_range(0, 2), $urandom, $urandom);
    end
    cfg_dir = $urandom; cfg_out = $urandom; cfg_en = $urandom;
    mind = 2; maxd = 2; hang_addr = 0;
    exp_q.push_back('{1, BASE + 12'd3, 32'd6});
    exp_q.push_back('{1, BASE + 12'd4, 32'(cfg_dir[6])});
    @(posedge clk);
    #1;
    first_pin = 6; last_pin = 9; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    for (int i = 0; i < 100 && !(csr_req && csr_addr == BASE + 12'd5); i++) @(negedge clk);
    chk("midop_reached_w_out", csr_addr, BASE + 12'd5);
    #2;
    reset = 1;
    #1;
    chk("midop_req_dropped", csr_req, 0);
    chk("midop_outputs", {busy, done, err, csr_we, csr_addr, csr_wdata, sts_q, in_q}, 0);
    chk("midop_txn_queue_empty", exp_q.size(), 0);
    m_sts = 0; m_in = 0;
    k = n_done;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (20) @(posedge clk);
    chk("midop_no_done", n_done, k);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
